// File: rtl/alu_seq.sv
// alu_seq: multicycle ALU for the Cpu16 family.
// Logic, add/sub, shift and rotate ops complete one clock after acceptance.
// MUL runs a shift-add engine for BITS clocks.
// DIV/REM run a restoring divider for 2*BITS clocks.
// out/out2/c only change when an op completes.
module alu_seq #(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            start,
    input  logic [3:0]      op_id,
    input  logic [BITS-1:0] op1,
    input  logic [BITS-1:0] op2,
    input  logic [BITS-1:0] op3,
    output logic [BITS-1:0] out,
    output logic [BITS-1:0] out2,
    output logic            z,
    output logic            c,
    output logic            busy,
    output logic            done
);
    localparam int            CW       = $clog2(2 * BITS);
    localparam logic [CW-1:0] MUL_LAST = CW'(BITS - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(2 * BITS - 1);

    localparam logic [3:0] OP_NOP = 4'd0,  OP_AND = 4'd1,  OP_OR  = 4'd2,  OP_XOR = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SUB = 4'd6,  OP_SBC = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_RLC = 4'd10, OP_RRC = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12, OP_DIV = 4'd13, OP_CMP = 4'd14, OP_REM = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t            state_q, state_d;
    logic [BITS-1:0]   out_q, out_d, out2_q, out2_d;
    logic              c_q, c_d, done_q, done_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    // acc holds {hi,lo} product during MUL, and the shifting dividend/quotient during DIV
    logic [2*BITS-1:0] acc_q, acc_d;
    logic [BITS-1:0]   rem_q, rem_d, opb_q, opb_d;
    logic              is_rem_q, is_rem_d;

    logic [BITS:0]     mul_sum;
    logic [2*BITS-1:0] mul_next;
    logic [BITS:0]     div_sh, div_diff;
    logic              div_ge;
    logic [BITS-1:0]   div_rem_next;
    logic [2*BITS-1:0] div_quo_next;
    logic [BITS:0]     arith;

    // One iteration of the shift-add multiplier and the restoring divider
    always_comb begin
        mul_sum      = {1'b0, acc_q[2*BITS-1:BITS]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next     = {mul_sum, acc_q[BITS-1:1]};
        // remainder stays below the divisor, so the borrow bit alone decides the quotient bit
        div_sh       = {rem_q, acc_q[2*BITS-1]};
        div_diff     = div_sh - {1'b0, opb_q};
        div_ge       = ~div_diff[BITS];
        div_rem_next = div_ge ? div_diff[BITS-1:0] : div_sh[BITS-1:0];
        div_quo_next = {acc_q[2*BITS-2:0], div_ge};
    end

    // Single-cycle add/subtract family with carry/borrow in bit BITS
    always_comb begin
        arith = '0;
        case (op_id)
            OP_ADD:  arith = {1'b0, op1} + {1'b0, op2};
            OP_ADC:  arith = {1'b0, op1} + {1'b0, op2} + {{BITS{1'b0}}, c_q};
            OP_SBC:  arith = {1'b0, op1} - {1'b0, op2} - {{BITS{1'b0}}, c_q};
            default: arith = {1'b0, op1} - {1'b0, op2};
        endcase
    end

    // Next-state logic: accept ops in IDLE, step engines, publish results on completion
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        out2_d   = out2_q;
        c_d      = c_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opb_d    = opb_q;
        is_rem_d = is_rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d = 1'b1;
                    case (op_id)
                        OP_NOP: ;
                        OP_AND: out_d = op1 & op2;
                        OP_OR:  out_d = op1 | op2;
                        OP_XOR: out_d = op1 ^ op2;
                        OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: {c_d, out_d} = arith;
                        OP_SHL: out_d = op1 << op2;
                        OP_SHR: out_d = op1 >> op2;
                        OP_RLC: {c_d, out_d} = {op1, c_q};
                        OP_RRC: {out_d, c_d} = {c_q, op1};
                        OP_MUL: begin
                            done_d  = 1'b0;
                            state_d = S_MUL;
                            acc_d   = {{BITS{1'b0}}, op2};
                            opb_d   = op1;
                            cnt_d   = '0;
                        end
                        OP_DIV, OP_REM: begin
                            if (op3 == '0) begin
                                // divide by zero completes immediately with status set
                                c_d = 1'b1;
                                if (op_id == OP_DIV) begin
                                    out_d  = '1;
                                    out2_d = '1;
                                end else begin
                                    out_d  = op1;
                                    out2_d = '0;
                                end
                            end else begin
                                done_d   = 1'b0;
                                state_d  = S_DIV;
                                acc_d    = {op2, op1};
                                rem_d    = '0;
                                opb_d    = op3;
                                is_rem_d = (op_id == OP_REM);
                                cnt_d    = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == MUL_LAST) begin
                    out_d   = mul_next[BITS-1:0];
                    out2_d  = mul_next[2*BITS-1:BITS];
                    c_d     = |mul_next[2*BITS-1:BITS];
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                acc_d = div_quo_next;
                rem_d = div_rem_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == DIV_LAST) begin
                    out_d   = is_rem_q ? div_rem_next : div_quo_next[BITS-1:0];
                    out2_d  = is_rem_q ? '0 : div_quo_next[2*BITS-1:BITS];
                    c_d     = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and architectural result registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            out2_q  <= '0;
            c_q     <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            out2_q  <= out2_d;
            c_q     <= c_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // Engine working registers; only meaningful while the FSM is out of IDLE
    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        rem_q    <= rem_d;
        opb_q    <= opb_d;
        is_rem_q <= is_rem_d;
    end

    assign out  = out_q;
    assign out2 = out2_q;
    assign c    = c_q;
    assign done = done_q;
    assign busy = (state_q != S_IDLE);
    assign z    = (out_q == '0);
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised multicycle ALU for the Cpu16 family; next generation of the single-cycle ALU.
- Single-cycle logic and add/sub ops are unchanged in kind.
- MUL, DIV and REM become iterative (shift-add / restoring) engines, removing the wide combinational multiplier and divider from the critical path.
- The CPU issues an op with a start/done handshake and stalls on busy.

Parameters:
- BITS, 16: datapath width; legal range 4..32.

Ports:
- clk      input   1         system clock; all logic on rising edge
- nrst     input   1         synchronous reset, active low
- start    input   1         issue strobe; operands and op_id sampled when start=1 and busy=0
- op_id    input   4         operation code (see Behaviour)
- op1      input   BITS      operand 1 / dividend low word
- op2      input   BITS      operand 2 / shift count / dividend high word
- op3      input   BITS      divisor (DIV/REM only)
- out      output  BITS      result low word
- out2     output  BITS      result high word (MUL/DIV/REM)
- z        output  1         zero flag, combinational: out == 0
- c        output  1         carry / status flag, registered
- busy     output  1         multicycle op in progress
- done     output  1         one-cycle pulse: result valid this cycle

Behaviour:
- Reset (nrst=0 at a clk edge): out=0, out2=0, c=0, busy=0, done=0, FSM to IDLE, iteration counter 0. Reset aborts any op in flight; no partial result is ever written.
- Op codes:
  - 0 NOP: done only; outputs unchanged.
  - 1 AND; 2 OR; 3 XOR.
  - 4 ADD, 5 ADC, 6 SUB, 7 SBC, 14 CMP: {c,out} = {0,op1} ± {0,op2} (± c for ADC/SBC); c = carry/borrow. CMP is identical to SUB.
  - 8 SHL: out = op1 << op2. 9 SHR: out = op1 >> op2. Logical shifts; a count >= BITS gives 0. c unchanged.
  - 10 RLC: {c,out} <= {op1, c}. 11 RRC: {out,c} <= {c, op1}.
  - 12 MUL: {out2,out} = op1*op2, unsigned; c = (out2 != 0).
  - 13 DIV: {out2,out} = {op2,op1} / op3, unsigned, 2*BITS-bit quotient.
  - 15 REM: out = {op2,op1} % op3; out2 = 0.
  - Logic ops and NEG-free ops (AND/OR/XOR/SHL/SHR) leave c unchanged.
- Single-cycle ops (all except 12, 13, 15):
  - start accepted at edge n; out, out2 and c are updated at edge n+1 with done=1 for that cycle; busy stays 0.
  - out2 is unchanged by single-cycle ops.
- MUL:
  - FSM IDLE -> MUL; operands are latched at acceptance.
  - One shift-add step per clock, BITS steps.
  - busy=1 from edge n+1 through the last step.
  - Result, c and done=1 appear at edge n+BITS+1; busy=0 at the same edge.
- DIV / REM:
  - FSM IDLE -> DIV; restoring division, one quotient bit per clock, 2*BITS steps.
  - Result and done appear at edge n+2*BITS+1.
  - c=0 on normal completion.
- Divide by zero (op3=0 at acceptance):
  - No iteration; completes like a single-cycle op at edge n+1.
  - DIV: out = out2 = all ones. REM: out = op1, out2 = 0.
  - c=1 in both cases.
- During a multicycle op, out, out2 and c hold their previous values; internal accumulators are separate registers.
- start while busy=1 is ignored (not queued). The CPU must hold off until done.
- start in the same cycle that done=1 is accepted normally: back-to-back issue is allowed.
- done is high for exactly one cycle per accepted op, and never without a prior accepted start.
- op_id/operand changes after acceptance have no effect on the op in flight.
- Width rules: all arithmetic is unsigned. Products and quotients are exactly 2*BITS bits. Remainder < op3 always fits in BITS.

Test Plan:
- Reset mid-DIV: BITS=16, DIV op2=0, op1=100, op3=7, assert nrst=0 at step 10 -> next cycle busy=0, done=0, out=0, out2=0, c=0; no done pulse afterwards.
- ADD then ADC back-to-back: ADD op1=FFFF, op2=0001 -> done at n+1, out=0000, z=1, c=1. Next cycle ADC op1=0001, op2=0001 -> out=0003, c=0.
- MUL: op1=FFFF, op2=FFFF -> busy high 16 cycles, done at n+17 with out=0001, out2=FFFE, c=1. start pulsed mid-op is ignored.
- DIV/REM: {op2,op1}=0001_0000, op3=0003 -> DIV at n+33 gives out2=0000, out=5555, c=0. REM gives out=0001, out2=0000.
- Divide by zero: DIV op3=0 -> done at n+1, out=FFFF, out2=FFFF, c=1. REM op1=1234, op3=0 -> out=1234, out2=0, c=1.
- Shifts/rotate at BITS=4: SHL op1=0011, op2=4 -> out=0000. RLC op1=1000 with c=1 -> out=0001, c=1.
